// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: west-edge A-operand feeder for the FP8 systolic array.
//
// Takes one LANES-wide FP8 vector per cycle over valid/ready and injects it
// into the array with diagonal skew (lane i delayed i+1 cycles). Each tile
// runs through a one-cycle accumulator clear, the K-vector stream, and a
// LANES-cycle drain. The drain lets the last vector's highest lane reach the
// array before done is pulsed.
//
// Optional build macro: SA_FEEDER_STALL_CNT_EN
//   defined   -> stall_cnt counts STREAM cycles with in_valid low.
//                The count saturates at 16'hFFFF and is cleared in CLEAR.
//   undefined -> stall_cnt is tied to zero.
module sa_skew_feeder #(
  parameter int LANES = 4,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*8-1:0] in_data,
  output logic [LANES*8-1:0] lane_data,
  output logic [LANES-1:0]   lane_valid,
  output logic               acc_clear,
  output logic               acc_en,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  // The drain counter only has to reach LANES-1.
  localparam int             DW         = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(LANES - 1);
  localparam logic [KW-1:0]  K_MAX_W    = KW'(K_MAX);
  localparam logic [KW-1:0]  K_ONE      = KW'(1);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [KW-1:0]      k_len_r;
  logic [KW-1:0]      cnt_r;
  logic [KW-1:0]      cnt_inc_s;
  logic [DW-1:0]      drain_cnt_r;
  logic               start_ok_s;
  logic               accept_s;
  logic               last_accept_s;
  logic               drain_last_s;
  logic               in_ready_r;
  logic               acc_clear_r;
  logic               acc_en_r;
  logic               busy_r;
  logic               done_r;
  logic [LANES*8-1:0] stage0_data_s;
  logic               stage0_valid_s;

  // A tile length outside 1..K_MAX is rejected at start.
  assign start_ok_s     = (k_len != {KW{1'b0}}) && (k_len <= K_MAX_W);
  // in_ready_r is high exactly while the FSM is in STREAM.
  assign accept_s       = in_valid & in_ready_r;
  assign cnt_inc_s      = cnt_r + K_ONE;
  assign last_accept_s  = accept_s && (cnt_inc_s == k_len_r);
  assign drain_last_s   = (drain_cnt_r == DRAIN_LAST);
  // Accepted vectors enter the skew chains; otherwise a zero bubble enters.
  assign stage0_data_s  = accept_s ? in_data : {(LANES*8){1'b0}};
  assign stage0_valid_s = accept_s;

  // Next-state decode for the tile sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && start_ok_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_accept_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (drain_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the tile length when a legal start is taken in IDLE only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_r <= {KW{1'b0}};
    end else if ((state_r == ST_IDLE) && start && start_ok_s) begin
      k_len_r <= k_len;
    end
  end

  // Accepted-vector counter: zeroed in CLEAR, bumped on each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {KW{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      cnt_r <= {KW{1'b0}};
    end else if ((state_r == ST_STREAM) && accept_s) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Drain cycle counter: runs only in DRAIN, wraps to zero on the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt_r <= {DW{1'b0}};
    end else if ((state_r == ST_DRAIN) && !drain_last_s) begin
      drain_cnt_r <= drain_cnt_r + DW'(1);
    end else begin
      drain_cnt_r <= {DW{1'b0}};
    end
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      acc_clear_r <= 1'b0;
      acc_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_STREAM);
      acc_clear_r <= (state_nxt_s == ST_CLEAR);
      acc_en_r    <= (state_nxt_s == ST_STREAM) || (state_nxt_s == ST_DRAIN);
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_r == ST_DRAIN) && drain_last_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign acc_clear = acc_clear_r;
  assign acc_en    = acc_en_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Skew chains. Lane i is an (i+1)-deep shift register that shifts every
  // cycle, because the array never back-pressures. Bubbles carry zero data,
  // so lane_data is zero whenever lane_valid is low.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [8*gi+7:0] data_r;
    logic [gi:0]     valid_r;

    if (gi == 0) begin : g_one
      // Single-stage chain for lane 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_r  <= 8'h00;
          valid_r <= 1'b0;
        end else begin
          data_r  <= stage0_data_s[7:0];
          valid_r <= stage0_valid_s;
        end
      end
    end else begin : g_many
      // Multi-stage chain: new byte enters at the bottom, output is the top.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_r  <= {(8*gi+8){1'b0}};
          valid_r <= {(gi+1){1'b0}};
        end else begin
          data_r  <= {data_r[8*gi-1:0], stage0_data_s[8*gi +: 8]};
          valid_r <= {valid_r[gi-1:0], stage0_valid_s};
        end
      end
    end

    assign lane_data[8*gi +: 8] = data_r[8*gi +: 8];
    assign lane_valid[gi]       = valid_r[gi];
  end

`ifdef SA_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Upstream starvation counter. It saturates, is cleared per tile, and holds in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (state_r == ST_CLEAR) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_STREAM) && !in_valid && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
